// File: rtl/inst_fetch_cache.sv
// Instruction-fetch stage with a direct-mapped, one-word-per-line instruction cache.
// Owns the PC, issues fetch addresses and delivers one registered instruction per cycle.
module inst_fetch_cache #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned ADDR_W     = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  input  logic [5:0]  stall,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        mem_pc_done,
  input  logic [31:0] mem_inst,
  input  logic [31:0] mem_pc_num,
  output logic [31:0] mem_pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        stall_req
);

  localparam int unsigned Lines = 1 << INDEX_BITS;
  localparam int unsigned TagW  = ADDR_W - 2 - INDEX_BITS;

  typedef enum logic {StRun, StMiss} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       if_pc_q, if_pc_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d;
  logic [Lines-1:0]  valid_q, valid_d;
  logic [TagW-1:0]   tag_mem  [Lines];
  logic [31:0]       data_mem [Lines];

  logic [INDEX_BITS-1:0] idx;
  logic [TagW-1:0]       tag;
  logic                  uncached;
  logic                  hit;
  logic                  resp_match;
  logic                  fill_we;
  logic                  unused_stall;

  assign idx          = pc_q[INDEX_BITS+1:2];
  assign tag          = pc_q[ADDR_W-1:2+INDEX_BITS];
  assign uncached     = (pc_q[17:16] == 2'b11);
  assign hit          = valid_q[idx] && (tag_mem[idx] == tag) && !uncached;
  assign resp_match   = mem_pc_done && (mem_pc_num == pc_q);
  // Any response for the current PC fills the line, whatever the state or redirect.
  assign fill_we      = rdy_in && resp_match && !uncached;
  assign unused_stall = ^{stall[5:2], stall[0]};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    valid_d    = valid_q;
    if (fill_we) begin
      valid_d[idx] = 1'b1;
    end
    if (rdy_in) begin
      if (branch_en) begin
        pc_d       = branch_target;
        if_valid_d = 1'b0;
        state_d    = StRun;
      end else if (!stall[1]) begin
        unique case (state_q)
          StRun: begin
            if (hit) begin
              if_pc_d    = pc_q;
              if_inst_d  = data_mem[idx];
              if_valid_d = 1'b1;
              pc_d       = pc_q + 32'd4;
            end else begin
              if_valid_d = 1'b0;
              state_d    = StMiss;
            end
          end
          StMiss: begin
            if_valid_d = 1'b0;
            if (resp_match) begin
              state_d = StRun;
              // Uncached words bypass the array and go straight to IF/ID.
              if (uncached) begin
                if_pc_d    = pc_q;
                if_inst_d  = mem_inst;
                if_valid_d = 1'b1;
                pc_d       = pc_q + 32'd4;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      pc_q       <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_inst;
    end
  end

  assign mem_pc    = pc_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;
  assign stall_req = (state_q == StMiss) && !branch_en;

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Bench for inst_fetch_cache: behavioural 5-cycle memory, program-order scoreboard,
// directed scenarios followed by randomized stall/freeze/branch traffic.
module tb_inst_fetch_cache;

  logic        clk;
  logic        rst;
  logic        rdy_in;
  logic [5:0]  stall;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        mem_pc_done;
  logic [31:0] mem_inst;
  logic [31:0] mem_pc_num;
  logic [31:0] mem_pc;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  inst_fetch_cache #(.INDEX_BITS(6), .ADDR_W(18)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy_in        (rdy_in),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .mem_pc_done   (mem_pc_done),
    .mem_inst      (mem_inst),
    .mem_pc_num    (mem_pc_num),
    .mem_pc        (mem_pc),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_valid      (if_valid),
    .stall_req     (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: any address holds a fixed word; address 0 holds 0x00000013.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] t);
    exp_q.delete();
    for (int k = 0; k < 64; k++) exp_q.push_back(t + 32'(k * 4));
  endtask

  // Called just after a rising edge; the redirect is taken on the following edge.
  task automatic do_branch(input logic [31:0] t);
    rdy_in        = 1'b1;
    branch_en     = 1'b1;
    branch_target = t;
    @(posedge clk); #1;
    branch_en = 1'b0;
    push_seq(t);
  endtask

  task automatic wait_deliv(input int maxc, output bit got, output bit saw_stall);
    got = 1'b0;
    saw_stall = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(posedge clk); #1;
      if (stall_req) saw_stall = 1'b1;
      if (if_valid) got = 1'b1;
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h40;
      2: return 32'h100;
      3: return 32'h30000;
      4: return 32'h2FFF8;
      5: return 32'($urandom_range(0, 255)) << 2;
      6: return 32'($urandom_range(0, 32'h7FFF)) << 2;
      default: return 32'h80;
    endcase
  endfunction

  // Memory controller model: samples mem_pc when idle, answers 5 cycles later.
  initial begin
    logic [31:0] maddr;
    int          cnt;
    bit          busy;
    mem_pc_done = 1'b0;
    mem_inst    = '0;
    mem_pc_num  = '0;
    busy        = 1'b0;
    cnt         = 0;
    maddr       = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        busy        = 1'b0;
        mem_pc_done = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          mem_pc_done = 1'b1;
          mem_inst    = mem_word(maddr);
          mem_pc_num  = maddr;
          busy        = 1'b0;
        end
      end else begin
        mem_pc_done = 1'b0;
        maddr       = mem_pc;
        busy        = 1'b1;
        cnt         = 5;
      end
    end
  end

  // Monitor: classifies each edge by the inputs it saw, then checks hold/kill/delivery.
  initial begin
    logic        l_rdy, l_st1, l_br;
    logic        prv_v;
    logic [31:0] prv_pc, prv_inst, e;
    l_rdy = 1'b0; l_st1 = 1'b0; l_br = 1'b0;
    prv_v = 1'b0; prv_pc = '0; prv_inst = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prv_v = 1'b0; prv_pc = '0; prv_inst = '0;
      end else begin
        if (!l_rdy || (l_st1 && !l_br)) begin
          chk("hold_valid", 32'(if_valid), 32'(prv_v));
          chk("hold_pc", if_pc, prv_pc);
          chk("hold_inst", if_inst, prv_inst);
        end else if (l_br) begin
          chk("branch_kill", 32'(if_valid), 32'd0);
        end else if (if_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got pc %08h expected no delivery", if_pc);
          end else begin
            e = exp_q.pop_front();
            chk("deliv_pc", if_pc, e);
            chk("deliv_inst", if_inst, mem_word(e));
            chk("mem_pc_next", mem_pc, e + 32'd4);
          end
        end
        if (branch_en) chk("stall_req_on_branch", 32'(stall_req), 32'd0);
        prv_v = if_valid; prv_pc = if_pc; prv_inst = if_inst;
      end
      l_rdy = rdy_in; l_st1 = stall[1]; l_br = branch_en;
    end
  end

  initial begin
    bit          got, ss, found;
    int          cnt, since;
    logic [31:0] s_pc, s_inst, s_mp;
    logic        s_v;
    rst           = 1'b1;
    rdy_in        = 1'b1;
    stall         = '0;
    branch_en     = 1'b0;
    branch_target = '0;
    #2 rst = 1'b0;
    #10;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mem_pc", mem_pc, 32'd0);
    chk("rst_stall_req", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    push_seq(32'h0);
    rst = 1'b1;

    // Cold start
    wait_deliv(40, got, ss);
    chk("cold_got", 32'(got), 32'd1);
    chk("cold_stall_req", 32'(ss), 32'd1);
    chk("cold_pc", if_pc, 32'h0);
    chk("cold_inst", if_inst, 32'h00000013);
    chk("cold_mem_pc", mem_pc, 32'h4);

    // Run to 0xC, then loop back: four back-to-back hits
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      @(posedge clk); #1;
      if (if_valid && if_pc == 32'hC) found = 1'b1;
    end
    chk("seq_reach_c", 32'(found), 32'd1);
    do_branch(32'h0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (if_valid && !stall_req) cnt++;
    end
    chk("loop_rehit_cnt", 32'(cnt), 32'd4);
    chk("loop_last_pc", if_pc, 32'hC);

    // Branch away while a miss is outstanding
    do_branch(32'h40);
    @(posedge clk); #1;
    chk("mid_miss_stall", 32'(stall_req), 32'd1);
    do_branch(32'h80);
    wait_deliv(60, got, ss);
    chk("redirect_got", 32'(got), 32'd1);
    chk("redirect_pc", if_pc, 32'h80);

    // Conflict on index 0
    do_branch(32'h100);
    wait_deliv(60, got, ss);
    chk("conflict_pc", if_pc, 32'h100);
    do_branch(32'h0);
    wait_deliv(60, got, ss);
    chk("conflict_remiss", 32'(ss), 32'd1);
    chk("conflict_pc0", if_pc, 32'h0);

    // Stall and freeze hold
    do_branch(32'h0);
    wait_deliv(60, got, ss);
    s_pc = if_pc; s_inst = if_inst; s_v = if_valid;
    stall = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_hold_pc", if_pc, s_pc);
      chk("stall_hold_inst", if_inst, s_inst);
      chk("stall_hold_valid", 32'(if_valid), 32'(s_v));
    end
    stall  = '0;
    rdy_in = 1'b0;
    s_mp   = mem_pc;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("frozen_mem_pc", mem_pc, s_mp);
      chk("frozen_if_pc", if_pc, s_pc);
    end
    rdy_in = 1'b1;

    // Uncached region is never retained
    do_branch(32'h30000);
    wait_deliv(60, got, ss);
    chk("uncached_got", 32'(got), 32'd1);
    chk("uncached_pc", if_pc, 32'h30000);
    do_branch(32'h30000);
    wait_deliv(60, got, ss);
    chk("uncached_remiss", 32'(ss), 32'd1);
    chk("uncached_pc2", if_pc, 32'h30000);

    // Randomized traffic
    since = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      rdy_in   = ($urandom_range(0, 9) != 0);
      stall    = 6'($urandom);
      stall[1] = ($urandom_range(0, 5) == 0);
      since++;
      if (rdy_in && (since > 25 || $urandom_range(0, 19) == 0)) begin
        since = 0;
        do_branch(pick_target());
      end
    end
    rdy_in = 1'b1;
    stall  = '0;

    // Async reset in the middle of a miss invalidates the cache
    do_branch(32'h0);
    wait_deliv(60, got, ss);
    chk("pre_reset_hit_pc", if_pc, 32'h0);
    do_branch(32'h30100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_miss", 32'(stall_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("areset_if_valid", 32'(if_valid), 32'd0);
    chk("areset_if_pc", if_pc, 32'd0);
    chk("areset_if_inst", if_inst, 32'd0);
    chk("areset_mem_pc", mem_pc, 32'd0);
    chk("areset_stall_req", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    push_seq(32'h0);
    rst = 1'b1;
    wait_deliv(40, got, ss);
    chk("post_reset_got", 32'(got), 32'd1);
    chk("post_reset_remiss", 32'(ss), 32'd1);
    chk("post_reset_pc", if_pc, 32'h0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
